plc_panel_conditioner: RTL and testbench



---
 rtl/plc_panel_pkg.sv | 20 ++
 rtl/panel_debounce.sv | 48 ++++
 rtl/plc_panel_conditioner.sv | 161 ++++++++++++++++
 tb/tb_plc_panel_conditioner.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/plc_panel_pkg.sv
// Shared types and defaults for the lathe operator-panel conditioner.
package plc_panel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_AUTO  = 2'd1,
    ST_MAN   = 2'd2,
    ST_FAULT = 2'd3
  } panel_state_t;

  localparam int unsigned DEB_CYCLES_DEF      = 16;
  localparam int unsigned CONFLICT_CYCLES_DEF = 8;
  localparam int unsigned STUCK_CYCLES_DEF    = 1024;

  // Bits needed for a counter that counts 0 .. n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/panel_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one contact.
module panel_debounce
  import plc_panel_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_deb
);

  localparam int unsigned CW = cnt_width(DEB_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb;
  logic [CW-1:0] r_cnt;

  // Synchronise the raw contact into the clock domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after DEB_CYCLES consecutive differing cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_deb <= 1'b0;
      r_cnt <= '0;
    end else if (r_sync2 == r_deb) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
      r_deb <= r_sync2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_deb = r_deb;

endmodule

// File: rtl/plc_panel_conditioner.sv
// Operator-panel front end: debounces start/AUTO/MAN contacts, resolves the
// mode with MAN priority, interlocks mode changes against a held start and
// latches selector faults. Define PANEL_STUCK_DETECT_EN to also fault on a
// granted start held for STUCK_CYCLES.
module plc_panel_conditioner
  import plc_panel_pkg::*;
#(
  parameter int unsigned DEB_CYCLES      = DEB_CYCLES_DEF,
  parameter int unsigned CONFLICT_CYCLES = CONFLICT_CYCLES_DEF,
  parameter int unsigned STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_start,
  input  logic raw_auto,
  input  logic raw_man,
  output logic start,
  output logic auto_mode,
  output logic man_mode,
  output logic fault,
  output logic mode_chg
);

  localparam int unsigned CONF_W = cnt_width(CONFLICT_CYCLES);

  logic              w_dstart;
  logic              w_dauto;
  logic              w_dman;
  logic              w_conf_hit;
  logic              w_stuck_hit;
  logic              w_armed_next;
  panel_state_t      r_state;
  panel_state_t      w_next;
  logic [CONF_W-1:0] r_conf_cnt;
  logic              r_armed;
  logic              r_dstart_q;
  logic              r_start;
  logic              r_auto;
  logic              r_man;
  logic              r_fault;
  logic              r_mode_chg;

  panel_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .i_clk(clk), .i_rst_n(rst_n), .i_raw(raw_start), .o_deb(w_dstart)
  );
  panel_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_auto (
    .i_clk(clk), .i_rst_n(rst_n), .i_raw(raw_auto), .o_deb(w_dauto)
  );
  panel_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_man (
    .i_clk(clk), .i_rst_n(rst_n), .i_raw(raw_man), .o_deb(w_dman)
  );

  // Count consecutive cycles with both selector contacts closed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conf_cnt <= '0;
    end else if (!(w_dauto && w_dman)) begin
      r_conf_cnt <= '0;
    end else if (r_conf_cnt != CONF_W'(CONFLICT_CYCLES - 1)) begin
      r_conf_cnt <= r_conf_cnt + CONF_W'(1);
    end
  end

  assign w_conf_hit = w_dauto & w_dman & (r_conf_cnt == CONF_W'(CONFLICT_CYCLES - 1));

`ifdef PANEL_STUCK_DETECT_EN
  localparam int unsigned STUCK_W = cnt_width(STUCK_CYCLES);

  logic [STUCK_W-1:0] r_stuck_cnt;

  // Measure how long a granted start has been held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stuck_cnt <= '0;
    end else if (!r_start) begin
      r_stuck_cnt <= '0;
    end else if (r_stuck_cnt != STUCK_W'(STUCK_CYCLES - 1)) begin
      r_stuck_cnt <= r_stuck_cnt + STUCK_W'(1);
    end
  end

  assign w_stuck_hit = r_start & (r_stuck_cnt == STUCK_W'(STUCK_CYCLES - 1));
`else
  // Without stuck detection only a degenerate zero limit could trip.
  assign w_stuck_hit = (STUCK_CYCLES == 32'd0);
`endif

  // Mode state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: MAN priority, start interlock, fault overrides everything.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_dman)       w_next = ST_MAN;
        else if (w_dauto) w_next = ST_AUTO;
      end
      ST_AUTO: begin
        if (!w_dstart) begin
          if (w_dman)        w_next = ST_MAN;
          else if (!w_dauto) w_next = ST_IDLE;
        end
      end
      ST_MAN: begin
        if (!w_dstart && !w_dman) begin
          w_next = w_dauto ? ST_AUTO : ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (!w_dauto && !w_dman && !w_dstart) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_conf_hit || w_stuck_hit) w_next = ST_FAULT;
  end

  // Arm start only on a fresh press inside a stable AUTO/MAN state.
  always_comb begin
    w_armed_next = r_armed;
    if ((w_next != r_state) || !w_dstart) begin
      w_armed_next = 1'b0;
    end else if (w_dstart && !r_dstart_q && ((r_state == ST_AUTO) || (r_state == ST_MAN))) begin
      w_armed_next = 1'b1;
    end
  end

  // Registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed    <= 1'b0;
      r_dstart_q <= 1'b0;
      r_start    <= 1'b0;
      r_auto     <= 1'b0;
      r_man      <= 1'b0;
      r_fault    <= 1'b0;
      r_mode_chg <= 1'b0;
    end else begin
      r_armed    <= w_armed_next;
      r_dstart_q <= w_dstart;
      r_start    <= w_dstart & w_armed_next;
      r_auto     <= (w_next == ST_AUTO);
      r_man      <= (w_next == ST_MAN);
      r_fault    <= (w_next == ST_FAULT);
      r_mode_chg <= (w_next != r_state);
    end
  end

  assign start     = r_start;
  assign auto_mode = r_auto;
  assign man_mode  = r_man;
  assign fault     = r_fault;
  assign mode_chg  = r_mode_chg;

endmodule

// File: tb/tb_plc_panel_conditioner.sv
// Bench for plc_panel_conditioner: cycle model of the panel rules plus
// hand-computed checkpoints. Honours PANEL_STUCK_DETECT_EN.
module tb_plc_panel_conditioner;

  localparam int unsigned DEB   = 4;
  localparam int unsigned CONF  = 8;
  localparam int unsigned STUCK = 64;

  localparam int M_IDLE  = 0;
  localparam int M_AUTO  = 1;
  localparam int M_MAN   = 2;
  localparam int M_FAULT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic raw_start = 1'b1;
  logic raw_auto = 1'b1;
  logic raw_man = 1'b1;
  logic start, auto_mode, man_mode, fault, mode_chg;

  int checks = 0;
  int failures = 0;

  plc_panel_conditioner #(
    .DEB_CYCLES(DEB), .CONFLICT_CYCLES(CONF), .STUCK_CYCLES(STUCK)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .raw_start(raw_start), .raw_auto(raw_auto), .raw_man(raw_man),
    .start(start), .auto_mode(auto_mode), .man_mode(man_mode),
    .fault(fault), .mode_chg(mode_chg)
  );

  always #10 clk = ~clk;

  // Model: index 0 = start, 1 = auto, 2 = man.
  int m_s1 [3];
  int m_s2 [3];
  int m_d  [3];
  int m_run[3];
  int m_mode, m_conf, m_stuck, m_arm, m_prev_ds;
  logic [4:0] m_exp;  // {start, auto, man, fault, chg}

  function automatic int sel_mode(input int da, input int dm);
    return dm ? M_MAN : (da ? M_AUTO : M_IDLE);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_d[i] = 0; m_run[i] = 0;
      end
      m_mode = M_IDLE; m_conf = 0; m_stuck = 0; m_arm = 0; m_prev_ds = 0;
      m_exp = 5'b00000;
    end else begin
      int ds, da, dm, nm, chg;
      ds = m_d[0]; da = m_d[1]; dm = m_d[2];
      if (m_mode == M_FAULT)
        nm = (!da && !dm && !ds) ? M_IDLE : M_FAULT;
      else if (m_mode == M_IDLE || !ds)
        nm = sel_mode(da, dm);
      else
        nm = m_mode;
      m_conf = (da && dm) ? m_conf + 1 : 0;
      if (m_conf >= CONF) nm = M_FAULT;
`ifdef PANEL_STUCK_DETECT_EN
      m_stuck = m_exp[4] ? m_stuck + 1 : 0;
      if (m_stuck >= STUCK) nm = M_FAULT;
`endif
      chg = (nm != m_mode);
      if (chg || !ds) m_arm = 0;
      else if (!m_prev_ds && (m_mode == M_AUTO || m_mode == M_MAN)) m_arm = 1;
      m_exp[4] = (ds != 0) && (m_arm != 0);
      m_exp[3] = (nm == M_AUTO);
      m_exp[2] = (nm == M_MAN);
      m_exp[1] = (nm == M_FAULT);
      m_exp[0] = (chg != 0);
      m_prev_ds = ds;
      m_mode = nm;
      for (int i = 0; i < 3; i++) begin
        if (m_s2[i] == m_d[i]) m_run[i] = 0;
        else begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] >= DEB) begin m_d[i] = m_s2[i]; m_run[i] = 0; end
        end
        m_s2[i] = m_s1[i];
      end
      m_s1[0] = int'(raw_start); m_s1[1] = int'(raw_auto); m_s1[2] = int'(raw_man);
    end
  end

  function automatic logic [4:0] outs();
    return {start, auto_mode, man_mode, fault, mode_chg};
  endfunction

  task automatic chk(input string nm, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got{s,a,m,f,c}=%b want=%b", nm, $time, got, exp);
    end
  endtask

  // Advance n cycles, comparing DUT against the model on every falling edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("model_cmp", outs(), m_exp);
    end
  endtask

  initial begin
    // Test 1: reset with all contacts closed, then AUTO only.
    tick(5);
    chk("t1_reset", outs(), 5'b00000);
    rst_n = 1'b1; raw_start = 1'b0; raw_man = 1'b0; raw_auto = 1'b1;
    tick(6);  chk("t1_auto_c6", outs(), 5'b00000);
    tick(1);  chk("t1_auto_c7", outs(), 5'b01001);
    tick(1);  chk("t1_chg_once", outs(), 5'b01000);

    // Test 2: short start glitch ignored; long press passes with latency 7.
    raw_start = 1'b1; tick(2); raw_start = 1'b0;
    tick(12); chk("t2_glitch", outs(), 5'b01000);
    raw_start = 1'b1;
    tick(6);  chk("t2_start_c6", outs(), 5'b01000);
    tick(1);  chk("t2_start_c7", outs(), 5'b11000);
    tick(3);  raw_start = 1'b0;
    tick(6);  chk("t2_rel_c6", outs(), 5'b11000);
    tick(1);  chk("t2_rel_c7", outs(), 5'b01000);
    tick(6);

    // Test 3: both selector contacts -> MAN, then FAULT after CONF cycles.
    raw_auto = 1'b0;
    tick(12); chk("t3_idle", outs(), 5'b00000);
    raw_auto = 1'b1; raw_man = 1'b1;
    tick(7);  chk("t3_man_prio", outs(), 5'b00101);
    tick(6);  chk("t3_pre_fault", outs(), 5'b00100);
    tick(1);  chk("t3_fault", outs(), 5'b00011);
    raw_auto = 1'b0; raw_man = 1'b0;
    tick(6);  chk("t3_fault_hold", outs(), 5'b00010);
    tick(1);  chk("t3_fault_exit", outs(), 5'b00001);
    tick(3);

    // Test 4: selector change interlocked by held start.
    raw_auto = 1'b1;
    tick(12); chk("t4_auto", outs(), 5'b01000);
    raw_start = 1'b1;
    tick(8);  chk("t4_start", outs(), 5'b11000);
    raw_auto = 1'b0; raw_man = 1'b1;
    tick(12); chk("t4_interlock", outs(), 5'b11000);
    raw_start = 1'b0;
    tick(6);  chk("t4_rel_c6", outs(), 5'b11000);
    tick(1);  chk("t4_enter_man", outs(), 5'b00101);
    tick(10); chk("t4_man_idle", outs(), 5'b00100);
    raw_start = 1'b1;
    tick(7);  chk("t4_repress", outs(), 5'b10100);
    raw_start = 1'b0;
    tick(10); chk("t4_released", outs(), 5'b00100);

    // Test 5: start held through AUTO entry is not passed.
    raw_man = 1'b0;
    tick(12); chk("t5_idle", outs(), 5'b00000);
    raw_start = 1'b1;
    tick(10); chk("t5_idle_start", outs(), 5'b00000);
    raw_auto = 1'b1;
    tick(7);  chk("t5_auto_entry", outs(), 5'b01001);
    tick(10); chk("t5_not_armed", outs(), 5'b01000);
    raw_start = 1'b0; tick(10);
    raw_start = 1'b1;
    tick(7);  chk("t5_rearmed", outs(), 5'b11000);

    // Test 6: stuck start (when enabled) and asynchronous reset.
    tick(STUCK - 1); chk("t6_pre_stuck", outs(), 5'b11000);
    tick(1);
`ifdef PANEL_STUCK_DETECT_EN
    chk("t6_stuck_fault", outs(), 5'b00011);
    tick(3); chk("t6_fault_hold", outs(), 5'b00010);
`else
    chk("t6_no_stuck", outs(), 5'b11000);
    tick(3); chk("t6_still_start", outs(), 5'b11000);
`endif
    #2 rst_n = 1'b0;
    #1 chk("t6_async_reset", outs(), 5'b00000);
    raw_start = 1'b0; raw_auto = 1'b0; raw_man = 1'b0;
    tick(3); chk("t6_in_reset", outs(), 5'b00000);
    rst_n = 1'b1;
    tick(10); chk("t6_after_reset", outs(), 5'b00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
